// File: rtl/div_sequencer.sv
// Multi-cycle restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} with a registered one-cycle ready pulse.
module div_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] rem_sh;
  logic [32:0] diff;
  logic        qbit;
  logic [31:0] quo_next;
  logic [31:0] rem_next;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    mag = (sgn && x[31]) ? (32'd0 - x) : x;
  endfunction

  function automatic logic [31:0] cond_neg(input logic [31:0] x, input logic en);
    cond_neg = en ? (32'd0 - x) : x;
  endfunction

  // One restoring step: the remainder stays below the divisor, so bit 32 of
  // the 33-bit difference is set exactly when the trial subtraction fails.
  always_comb begin
    rem_sh   = {rem_q, dvd_q[31]};
    diff     = rem_sh - {1'b0, dsr_q};
    qbit     = ~diff[32];
    quo_next = {dvd_q[30:0], qbit};
    rem_next = qbit ? diff[31:0] : rem_sh[31:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !annul) begin
          neg1_d = signed_div & opdata1[31];
          neg2_d = signed_div & opdata2[31];
          if (opdata2 == 32'd0) begin
            state_d = DIVZERO;
          end else begin
            dvd_d   = mag(opdata1, signed_div);
            dsr_d   = mag(opdata2, signed_div);
            rem_d   = 32'd0;
            cnt_d   = 5'd0;
            state_d = ON;
          end
        end
      end
      DIVZERO: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          state_d  = END;
          result_d = 64'd0;
          ready_d  = 1'b1;
        end
      end
      ON: begin
        if (annul) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_next;
          dvd_d = quo_next;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d  = END;
            result_d = {cond_neg(rem_next, neg1_q), cond_neg(quo_next, neg1_q ^ neg2_q)};
            ready_d  = 1'b1;
          end
        end
      end
      END: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // Datapath registers carry no reset; they are always reloaded on accept.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    dvd_q  <= dvd_d;
    dsr_q  <= dsr_d;
    neg1_q <= neg1_d;
    neg2_q <= neg2_d;
  end

  assign result = result_q;
  assign ready  = ready_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divider for the execute stage that implements DIV and DIVU. The hazard unit drives `start` while a divide is in E and the result is not ready. It holds the pipeline stalled until `ready` pulses. This block owns the divide state machine, operand capture, sign fix-up, the divide-by-zero path, and cancellation when an exception flushes E. The 64-bit result goes to the HI/LO write path as {remainder, quotient}.

## Interface
- No parameters; the datapath width is fixed at 32 bits.
- Clock and reset: one clock; reset is synchronous and active-high. Ports are `clk` and `rst`.
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `signed_div` in 1: 1 for DIV, 0 for DIVU; sampled only on accept.
- `opdata1` in 32: dividend; sampled only on accept.
- `opdata2` in 32: divisor; sampled only on accept.
- `start` in 1: divide request, level-held by the hazard unit until `ready`.
- `annul` in 1: cancel request, tied to the exception flush of E/M.
- `result` out 64: {remainder[63:32], quotient[31:0]}, registered.
- `ready` out 1: registered single-cycle pulse; `result` is valid in the same cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, DIVZERO, ON, END.
- IDLE:
  - `start & !annul` is an accept.
  - On accept, latch the operands, sign mode and sign bits.
  - If `opdata2 == 0`, go to DIVZERO; otherwise load the magnitudes, clear the iteration counter, and go to ON.
  - Otherwise stay in IDLE.
- Magnitudes when signed: two's-complement absolute value, taken as 32-bit unsigned. The magnitude of 0x80000000 is 0x80000000.
- ON:
  - Perform one restoring shift-subtract step per cycle, producing one quotient bit.
  - The partial remainder is 33 bits; the comparison is unsigned.
  - The counter runs 0..31.
  - After the step with count 31, go to END.
- END:
  - On entry, `result` and `ready` are registered.
  - Stay one cycle, then go unconditionally to IDLE.
  - `start` is not sampled in END.
- DIVZERO: one cycle, then END, with `result = 64'h0`.
- Sign fix-up, applied when signed:
  - The quotient is negated if the operand signs differ.
  - The remainder is negated if the dividend is negative.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0; no trap is raised.
- Unsigned: no fix-up.
- `annul` in DIVZERO or ON: next state is IDLE. `ready` is not asserted and `result` keeps its previous value.
- `annul` in END: no effect. The pulse already on the output completes, and the hazard unit discards the instruction.
- Operand changes after accept are ignored until the next accept.

## Timing
- Reset values: state IDLE, `result = 0`, `ready = 0`, `busy = 0`, counter 0. Reset wins over every other input in the same cycle, including mid-ON; the next cycle is IDLE.
- Normal divide:
  - Accept in cycle T.
  - ON occupies cycles T+1 .. T+32.
  - END is cycle T+33, with `ready = 1` and `result` valid.
  - IDLE is cycle T+34.
  - A new accept is possible at T+34 at the earliest, so back-to-back divides issue every 34 cycles.
- Divide by zero: accept in T, DIVZERO in T+1, `ready` in T+2.
- `ready` is high for exactly one cycle per completed divide and never otherwise.
- `busy` is high from T+1 through the END cycle.
- The hazard loop is closed because `start` falls combinationally in the END cycle. `ready` must not be combinational from `start`.

## Test plan
- Unsigned 100 / 7, accept at T:
  - `ready` high only at T+33.
  - `result` = {32'd2, 32'd14}.
  - `busy` high T+1..T+33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x00000002): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, `ready` at T+33.
- Signed 0x80000000 / 0xFFFFFFFF gives {0, 0x80000000}.
- Unsigned 0xFFFFFFFF / 1 gives {0, 0xFFFFFFFF}.
- Divide by zero, both modes: `ready` at T+2 with `result` 0; no ON cycles are observed.
- Annul:
  - Start a divide, then pulse `annul` at T+10: IDLE at T+11 and no `ready`.
  - `result` keeps its prior value.
  - A fresh 9 / 3 accepted at T+12 gives `ready` at T+45 with {0, 3}.
- Reset and hold:
  - Assert `rst` at T+20 mid-ON: all outputs 0 and IDLE the next cycle.
  - Hold `start` high through END for two consecutive divides: exactly two `ready` pulses, 34 cycles apart.
